// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard logic.
//   hz_state_e   : hazard controller sequencing state (RUN / MEM_WAIT / ERROR)
//   FWD_*        : EX operand select encodings (register file, WB, MEM)
//   REG_NUM_SIZE : default register-number width
package pipeline_pkg;

  localparam int REG_NUM_SIZE = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_fwd_unit.sv
// EX-stage operand forwarding select generation (purely combinational).
// Ports:
//   rs1_e, rs2_e : source registers of the instruction in execute
//   rd_m,  we_m  : MEM-stage destination / write enable
//   rd_w,  we_w  : WB-stage destination / write enable
//   fwd_a, fwd_b : operand selects (FWD_RF / FWD_WB / FWD_MEM)
// The MEM stage holds the younger result, so it wins over WB.
module hazard_fwd_unit
  import pipeline_pkg::*;
#(
  parameter int REG_NUM_SIZE = pipeline_pkg::REG_NUM_SIZE
) (
  input  logic [REG_NUM_SIZE-1:0] rs1_e,
  input  logic [REG_NUM_SIZE-1:0] rs2_e,
  input  logic [REG_NUM_SIZE-1:0] rd_m,
  input  logic                    we_m,
  input  logic [REG_NUM_SIZE-1:0] rd_w,
  input  logic                    we_w,
  output logic [1:0]              fwd_a,
  output logic [1:0]              fwd_b
);

  function automatic logic [1:0] fwd_sel(input logic [REG_NUM_SIZE-1:0] rs);
    if (we_m && (rd_m != '0) && (rd_m == rs))      return FWD_MEM;
    else if (we_w && (rd_w != '0) && (rd_w == rs)) return FWD_WB;
    else                                           return FWD_RF;
  endfunction

  assign fwd_a = fwd_sel(rs1_e);
  assign fwd_b = fwd_sel(rs2_e);

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage hazard controller: load-use / RAW stalls, branch flushes,
// data-memory wait states with timeout, and EX forwarding selects.
// Optional feature: define FORWARDING_EN to enable EX operand forwarding;
// without it every RAW dependency on E/M/W stalls decode.
// Ports:
//   clk, rst                      : clock, synchronous active-low reset
//   rs1_d, rs2_d                  : decode source registers
//   rs1_e, rs2_e                  : execute source registers
//   rd_e, we_e, mem_reg_e         : EX destination, write enable, is-load
//   rd_m, we_m / rd_w, we_w       : MEM / WB destination and write enable
//   brn_taken_e                   : branch in EX resolved taken
//   mem_busy                      : data memory not ready this cycle
//   stall_f/d/e/m                 : hold pipeline registers
//   flush_d, flush_e              : load bubble into D / E registers
//   fwd_a, fwd_b                  : EX operand selects
//   stall_cnt                     : saturating count of stall_d cycles
//   mem_err                       : sticky memory timeout flag
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int REG_NUM_SIZE = pipeline_pkg::REG_NUM_SIZE,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_NUM_SIZE-1:0] rs1_d,
  input  logic [REG_NUM_SIZE-1:0] rs2_d,
  input  logic [REG_NUM_SIZE-1:0] rs1_e,
  input  logic [REG_NUM_SIZE-1:0] rs2_e,
  input  logic [REG_NUM_SIZE-1:0] rd_e,
  input  logic                    we_e,
  input  logic                    mem_reg_e,
  input  logic [REG_NUM_SIZE-1:0] rd_m,
  input  logic                    we_m,
  input  logic [REG_NUM_SIZE-1:0] rd_w,
  input  logic                    we_w,
  input  logic                    brn_taken_e,
  input  logic                    mem_busy,
  output logic                    stall_f,
  output logic                    stall_d,
  output logic                    stall_e,
  output logic                    stall_m,
  output logic                    flush_d,
  output logic                    flush_e,
  output logic [1:0]              fwd_a,
  output logic [1:0]              fwd_b,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic                    mem_err
);

  // wait_cnt counts busy cycles already spent; it never needs to exceed MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e          state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic               err_nxt;
  logic               hazard_d;
  logic [1:0]         fwd_a_raw, fwd_b_raw;

  // True when an enabled, non-x0 destination feeds either decode source.
  function automatic logic dep_d(input logic we,
                                 input logic [REG_NUM_SIZE-1:0] rd,
                                 input logic [REG_NUM_SIZE-1:0] rs1,
                                 input logic [REG_NUM_SIZE-1:0] rs2);
    return we && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

  logic load_use;
  assign load_use = mem_reg_e && dep_d(we_e, rd_e, rs1_d, rs2_d);

`ifdef FORWARDING_EN
  // Results from E (non-load), M and W are bypassed, so only a load in EX stalls.
  assign hazard_d = load_use;

  hazard_fwd_unit #(
    .REG_NUM_SIZE (REG_NUM_SIZE)
  ) u_fwd (
    .rs1_e (rs1_e),
    .rs2_e (rs2_e),
    .rd_m  (rd_m),
    .we_m  (we_m),
    .rd_w  (rd_w),
    .we_w  (we_w),
    .fwd_a (fwd_a_raw),
    .fwd_b (fwd_b_raw)
  );
`else
  // No bypass anywhere: decode must wait until every in-flight producer has retired.
  assign hazard_d = load_use
                  | dep_d(we_e, rd_e, rs1_d, rs2_d)
                  | dep_d(we_m, rd_m, rs1_d, rs2_d)
                  | dep_d(we_w, rd_w, rs1_d, rs2_d);
  assign fwd_a_raw = FWD_RF;
  assign fwd_b_raw = FWD_RF;

  logic unused_e_srcs;
  assign unused_e_srcs = ^{rs1_e, rs2_e};
`endif

  // Forwarding is forced to the register file while reset is asserted.
  assign fwd_a = rst ? fwd_a_raw : FWD_RF;
  assign fwd_b = rst ? fwd_b_raw : FWD_RF;

  always_comb begin
    // NOTE: every output and next-state variable gets a default first so no path leaves one unassigned (no latch).
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_nxt   = mem_err;

    if (!rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_busy) begin
            {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
            state_nxt = MEM_WAIT;
            wait_nxt  = WAIT_W'(1);
          end else if (brn_taken_e) begin
            // The redirect squashes the dependent instruction anyway, so no stall.
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (hazard_d) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        MEM_WAIT: begin
          // The cycle busy drops is still stalled; RUN rules apply from the next cycle,
          // which is also when a branch held in E gets serviced.
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          if (!mem_busy) begin
            state_nxt = RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
        ERROR: begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          err_nxt = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      mem_err  <= err_nxt;
      if (stall_d && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller. Expected combinational outputs are
// queued when inputs are driven and popped/compared at the following negedge;
// a small reference count tracks stall_cnt. Runs with MEM_TIMEOUT=8 and a
// narrow stall counter so saturation is reachable quickly.
module tb_hazard_controller;

  localparam int RN  = 5;
  localparam int TMO = 8;
  localparam int CW  = 6;

`ifdef FORWARDING_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [RN-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          we_e, mem_reg_e, we_m, we_w, brn_taken_e, mem_busy;
  logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_err;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_controller #(
    .REG_NUM_SIZE (RN),
    .MEM_TIMEOUT  (TMO),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .rd_e        (rd_e),
    .we_e        (we_e),
    .mem_reg_e   (mem_reg_e),
    .rd_m        (rd_m),
    .we_m        (we_m),
    .rd_w        (rd_w),
    .we_w        (we_w),
    .brn_taken_e (brn_taken_e),
    .mem_busy    (mem_busy),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .stall_e     (stall_e),
    .stall_m     (stall_m),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_cnt   (stall_cnt),
    .mem_err     (mem_err)
  );

  int total = 0;
  int bad   = 0;

  logic [9:0]    exp_q[$];
  string         tag_q[$];
  logic [CW-1:0] exp_cnt = '0;
  logic [CW-1:0] cnt_mark;

  // Output vector layout: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, fwd_a, fwd_b}
  function automatic logic [9:0] mk(input logic sf, input logic sd, input logic se, input logic sm,
                                    input logic fd, input logic fe,
                                    input logic [1:0] fa, input logic [1:0] fb);
    return {sf, sd, se, sm, fd, fe, fa, fb};
  endfunction

  localparam logic [9:0] Z    = 10'b00_0000_0000;
  localparam logic [9:0] RSTO = 10'b00_0011_0000;
  localparam logic [9:0] LU   = 10'b11_0001_0000;
  localparam logic [9:0] BR   = 10'b00_0011_0000;
  localparam logic [9:0] ALL  = 10'b11_1100_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Push expectation, compare at negedge, then cross the active edge and update the count model.
  task automatic cycle(input string tag, input logic [9:0] e);
    logic [9:0] e_pop;
    string      t_pop;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    e_pop = exp_q.pop_front();
    t_pop = tag_q.pop_front();
    check(t_pop, {22'd0, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, fwd_a, fwd_b}, {22'd0, e_pop});
    @(posedge clk);
    if (!rst)                                 exp_cnt = '0;
    else if (e_pop[8] && exp_cnt != '1)       exp_cnt = exp_cnt + 1'b1;
    #1;
  endtask

  task automatic idle();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    we_e = 1'b0; mem_reg_e = 1'b0; we_m = 1'b0; we_w = 1'b0;
    brn_taken_e = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    // Reset overrides busy and a live load-use hazard.
    idle();
    rst = 1'b0;
    mem_busy = 1'b1; mem_reg_e = 1'b1; we_e = 1'b1; rd_e = 5; rs1_d = 5;
    cycle("rst_outputs", RSTO);
    check("rst_cnt", {26'd0, stall_cnt}, 32'd0);
    check("rst_err", {31'd0, mem_err}, 32'd0);

    idle(); rst = 1'b1;
    cycle("run_idle", Z);

    // Load-use on rs1, cleared by a different rd, x0 ignored, then rs2.
    mem_reg_e = 1'b1; we_e = 1'b1; rd_e = 5; rs1_d = 5;
    cycle("lu_rs1", LU);
    rd_e = 6;
    cycle("lu_clear", Z);
    rd_e = 0; rs1_d = 0; rs2_d = 0;
    cycle("lu_x0", Z);
    rd_e = 9; rs1_d = 1; rs2_d = 9;
    cycle("lu_rs2", LU);
    check("cnt_lu", {26'd0, stall_cnt}, 32'd2);

    // Non-load dependencies: stall only without forwarding.
    idle(); we_m = 1'b1; rd_m = 7; rs2_d = 7;
    cycle("dep_mem", FWD_ON ? Z : LU);
    idle(); we_w = 1'b1; rd_w = 4; rs1_d = 4;
    cycle("dep_wb", FWD_ON ? Z : LU);
    idle(); we_e = 1'b1; rd_e = 8; rs1_d = 8;
    cycle("dep_alu", FWD_ON ? Z : LU);
    idle(); we_w = 1'b0; rd_w = 4; rs1_d = 4;
    cycle("dep_wb_disabled", Z);
    check("cnt_dep", {26'd0, stall_cnt}, {26'd0, exp_cnt});

    // Forwarding selects: MEM beats WB, then WB, then register file.
    idle(); we_m = 1'b1; rd_m = 3; we_w = 1'b1; rd_w = 3; rs1_e = 3;
    cycle("fwd_a_mem", mk(0, 0, 0, 0, 0, 0, FWD_ON ? 2'b10 : 2'b00, 2'b00));
    rd_m = 0;
    cycle("fwd_a_wb", mk(0, 0, 0, 0, 0, 0, FWD_ON ? 2'b01 : 2'b00, 2'b00));
    rd_w = 0;
    cycle("fwd_a_rf", Z);
    idle(); rs2_e = 12; we_m = 1'b0; rd_m = 12; we_w = 1'b1; rd_w = 12;
    cycle("fwd_b_wb", mk(0, 0, 0, 0, 0, 0, 2'b00, FWD_ON ? 2'b01 : 2'b00));
    we_m = 1'b1;
    cycle("fwd_b_mem", mk(0, 0, 0, 0, 0, 0, 2'b00, FWD_ON ? 2'b10 : 2'b00));

    // Branch wins over a simultaneous load-use; no stall counted.
    idle();
    cnt_mark = exp_cnt;
    brn_taken_e = 1'b1; mem_reg_e = 1'b1; we_e = 1'b1; rd_e = 5; rs1_d = 5;
    cycle("br_lu", BR);
    check("br_cnt", {26'd0, stall_cnt}, {26'd0, cnt_mark});

    // Three busy cycles plus the exit cycle stall; a branch arriving meanwhile waits.
    idle();
    cnt_mark = exp_cnt;
    mem_busy = 1'b1;
    cycle("mw_1", ALL);
    brn_taken_e = 1'b1;
    cycle("mw_2", ALL);
    cycle("mw_3", ALL);
    mem_busy = 1'b0;
    cycle("mw_exit", ALL);
    cycle("mw_branch", BR);
    check("mw_cnt", {26'd0, stall_cnt}, {26'd0, cnt_mark} + 32'd4);
    brn_taken_e = 1'b0;
    cycle("mw_run", Z);
    check("mw_err", {31'd0, mem_err}, 32'd0);

    // Timeout: mem_err sets after the 8th consecutive busy cycle and sticks.
    idle(); mem_busy = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle($sformatf("tmo_busy_%0d", i), ALL);
      check($sformatf("tmo_err_%0d", i), {31'd0, mem_err}, (i >= TMO) ? 32'd1 : 32'd0);
    end
    mem_busy = 1'b0;
    cycle("err_idle", ALL);
    check("err_sticky", {31'd0, mem_err}, 32'd1);
    brn_taken_e = 1'b1; mem_reg_e = 1'b1; we_e = 1'b1; rd_e = 5; rs1_d = 5;
    cycle("err_no_flush", ALL);
    idle();
    for (int i = 0; i < 60; i++) cycle("err_hold", ALL);
    check("cnt_model", {26'd0, stall_cnt}, {26'd0, exp_cnt});
    check("cnt_sat", {26'd0, stall_cnt}, 32'd63);
    check("err_still", {31'd0, mem_err}, 32'd1);

    // Reset leaves ERROR; then reset during MEM_WAIT returns straight to RUN.
    rst = 1'b0;
    cycle("rst_err_state", RSTO);
    rst = 1'b1;
    check("rst2_cnt", {26'd0, stall_cnt}, 32'd0);
    check("rst2_err", {31'd0, mem_err}, 32'd0);
    mem_busy = 1'b1;
    cycle("rmw_1", ALL);
    cycle("rmw_2", ALL);
    rst = 1'b0;
    cycle("rst_in_mw", RSTO);
    rst = 1'b1; mem_busy = 1'b0;
    cycle("after_rst_run", Z);
    check("after_rst_cnt", {26'd0, stall_cnt}, 32'd0);
    check("after_rst_err", {31'd0, mem_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
